// File: rtl/mcoi_onewire_id_pkg.sv
// Shared constants, state encoding and CRC helper for the 1-Wire ROM reader.
package McoiOneWirePkg;

    // READ ROM command understood by every single-drop 1-Wire serial number device
    localparam logic [7:0] ONEWIRE_CMD_READ_ROM = 8'h33;

    // Phase durations in microseconds
    localparam logic [9:0] T_RST   = 10'd480;
    localparam logic [9:0] T_PRES  = 10'd70;
    localparam logic [9:0] T_SLOT  = 10'd70;
    localparam logic [9:0] T_LOW1  = 10'd6;
    localparam logic [9:0] T_LOW0  = 10'd60;
    localparam logic [9:0] T_RSAMP = 10'd15;

    // x^8+x^5+x^4+1 in reflected (LSB-first) form
    localparam logic [7:0] CRC8_POLY_REFL = 8'h8C;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RST_LOW  = 3'd1,
        ST_RST_PRES = 3'd2,
        ST_RST_REC  = 3'd3,
        ST_TX_SLOT  = 3'd4,
        ST_RX_SLOT  = 3'd5,
        ST_CHECK    = 3'd6,
        ST_FINISH   = 3'd7
    } onewire_state_t;

    // One serial step of the Dallas CRC-8: shift right, fold in the polynomial on feedback
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[0] ^ din;
        return {1'b0, crc[7:1]} ^ (fb ? CRC8_POLY_REFL : 8'h00);
    endfunction

endpackage

// File: rtl/mcoi_onewire_id_crc8.sv
// Serial Dallas CRC-8 engine; a valid 64-bit ROM fed LSB first leaves remainder 0.
module onewire_crc8
    import McoiOneWirePkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       clear_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [7:0] crc_o
);

    logic [7:0] r_crc;

    // Remainder register: cleared at the start of a ROM read, advanced once per received bit
    always_ff @(posedge clk) begin
        if (!rstn || clear_i) begin
            r_crc <= 8'h00;
        end else if (en_i) begin
            r_crc <= crc8_step(r_crc, bit_i);
        end
    end

    assign crc_o = r_crc;

endmodule

// File: rtl/mcoi_onewire_id.sv
// Reads the 64-bit ROM of a DS2401-class 1-Wire serial number chip with a single
// READ ROM transaction, checks its CRC and holds the last good ID for diagnostics.
module mcoi_onewire_id
    import McoiOneWirePkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter bit AUTO_START  = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start_i,
    input  logic        dq_i,
    output logic        dq_oe_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [63:0] id_o,
    output logic        valid_o,
    output logic        no_presence_o,
    output logic        crc_err_o
);

    localparam int         DIV   = CLK_FREQ_HZ / 1_000_000;
    localparam int         PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [9:0] T_REC = T_RST - T_PRES;

    onewire_state_t   r_state;
    onewire_state_t   w_next;
    logic [PRE_W-1:0] r_pre;
    logic [9:0]       r_us;
    logic [5:0]       r_bit;
    logic             r_dq_s1;
    logic             r_dq_s2;
    logic             r_oe;
    logic             r_auto;
    logic             r_pres;
    logic [63:0]      r_shift;
    logic [63:0]      r_id;
    logic             r_valid;
    logic             r_nopres;
    logic             r_crcerr;

    logic             w_tick;
    logic             w_oe;
    logic             w_slot_end;
    logic             w_sample;
    logic             w_tx_bit;
    logic             w_crc_clear;
    logic             w_crc_en;
    logic [7:0]       w_crc;

    assign w_tick   = (r_pre == PRE_W'(DIV - 1));
    assign w_tx_bit = ONEWIRE_CMD_READ_ROM[r_bit[2:0]];

    // Next-state decode, bus drive and sample strobes for the current phase
    always_comb begin
        w_next     = r_state;
        w_oe       = 1'b0;
        w_slot_end = 1'b0;
        w_sample   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i || r_auto) w_next = ST_RST_LOW;
            end
            ST_RST_LOW: begin
                w_oe = 1'b1;
                if (w_tick && r_us == T_RST - 10'd1) w_next = ST_RST_PRES;
            end
            ST_RST_PRES: begin
                if (w_tick && r_us == T_PRES - 10'd1) begin
                    w_sample = 1'b1;
                    w_next   = ST_RST_REC;
                end
            end
            ST_RST_REC: begin
                if (w_tick && r_us == T_REC - 10'd1) w_next = r_pres ? ST_TX_SLOT : ST_FINISH;
            end
            ST_TX_SLOT: begin
                w_oe = (r_us < (w_tx_bit ? T_LOW1 : T_LOW0));
                if (w_tick && r_us == T_SLOT - 10'd1) begin
                    w_slot_end = 1'b1;
                    if (r_bit == 6'd7) w_next = ST_RX_SLOT;
                end
            end
            ST_RX_SLOT: begin
                w_oe = (r_us < T_LOW1);
                if (w_tick && r_us == T_RSAMP - 10'd1) w_sample = 1'b1;
                if (w_tick && r_us == T_SLOT - 10'd1) begin
                    w_slot_end = 1'b1;
                    if (r_bit == 6'd63) w_next = ST_CHECK;
                end
            end
            ST_CHECK:  w_next = ST_FINISH;
            ST_FINISH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Microsecond time base; restarts on every state entry and every bit slot
    always_ff @(posedge clk) begin
        if (!rstn || (w_next != r_state)) begin
            r_pre <= '0;
            r_us  <= '0;
            r_bit <= '0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_slot_end) begin
                r_us  <= '0;
                r_bit <= r_bit + 1'b1;
            end else if (w_tick) begin
                r_us <= r_us + 1'b1;
            end
        end
    end

    // State register, DQ synchroniser, registered bus drive and status flags
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_auto   <= AUTO_START;
            r_oe     <= 1'b0;
            r_pres   <= 1'b0;
            r_dq_s1  <= 1'b1;
            r_dq_s2  <= 1'b1;
            r_id     <= '0;
            r_valid  <= 1'b0;
            r_nopres <= 1'b0;
            r_crcerr <= 1'b0;
        end else begin
            r_state <= w_next;
            r_oe    <= w_oe;
            r_dq_s1 <= dq_i;
            r_dq_s2 <= r_dq_s1;
            if (r_state == ST_IDLE && w_next == ST_RST_LOW) begin
                r_auto   <= 1'b0;
                r_nopres <= 1'b0;
                r_crcerr <= 1'b0;
            end
            if (r_state == ST_RST_PRES && w_sample) r_pres <= ~r_dq_s2;
            if (r_state == ST_RST_REC && w_next == ST_FINISH) r_nopres <= 1'b1;
            if (r_state == ST_CHECK) begin
                if (w_crc == 8'h00) begin
                    r_id    <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_crcerr <= 1'b1;
                end
            end
        end
    end

    // ROM shift register, LSB first: the first received bit ends up in bit 0
    always_ff @(posedge clk) begin
        if (r_state == ST_RX_SLOT && w_sample) r_shift <= {r_dq_s2, r_shift[63:1]};
    end

    assign w_crc_clear = (r_state == ST_RST_REC) && (w_next == ST_TX_SLOT);
    assign w_crc_en    = (r_state == ST_RX_SLOT) && w_sample;

    onewire_crc8 u_crc8 (
        .clk     (clk),
        .rstn    (rstn),
        .clear_i (w_crc_clear),
        .en_i    (w_crc_en),
        .bit_i   (r_dq_s2),
        .crc_o   (w_crc)
    );

    assign dq_oe_o       = r_oe;
    assign busy_o        = (r_state != ST_IDLE) && (r_state != ST_FINISH);
    assign done_o        = (r_state == ST_FINISH);
    assign id_o          = r_id;
    assign valid_o       = r_valid;
    assign no_presence_o = r_nopres;
    assign crc_err_o     = r_crcerr;

endmodule

// File: tb/tb_mcoi_onewire_id.sv
// Bench for mcoi_onewire_id: open-drain bus with a behavioural DS2401-like slave,
// randomized ROMs and an expectation model built from the 1-Wire/CRC rules.
`timescale 1ns/1ns
module tb_mcoi_onewire_id;

    // 1 MHz clock: one cycle per microsecond keeps full transactions short
    localparam int CLK_HZ = 1_000_000;
    localparam int US     = CLK_HZ / 1_000_000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start_i = 1'b0;
    logic        dq_oe_o, busy_o, done_o, valid_o, no_presence_o, crc_err_o;
    logic [63:0] id_o;

    logic        slave_en = 1'b0;
    logic        slave_pull = 1'b0;
    logic [63:0] slave_rom = '0;
    wire         bus = !(dq_oe_o || slave_pull);

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;
    int n_done = 0;

    logic [63:0] e_id = '0;
    logic        e_valid = 1'b0;
    logic        e_nopres = 1'b0;
    logic        e_crcerr = 1'b0;

    always #(500 / US) clk = ~clk;

    mcoi_onewire_id #(
        .CLK_FREQ_HZ (CLK_HZ),
        .AUTO_START  (1'b1)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .start_i       (start_i),
        .dq_i          (bus),
        .dq_oe_o       (dq_oe_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .id_o          (id_o),
        .valid_o       (valid_o),
        .no_presence_o (no_presence_o),
        .crc_err_o     (crc_err_o)
    );

    always @(posedge clk) if (done_o) n_done <= n_done + 1;

    // Master bus-drive monitor: low widths and slot start times in microseconds
    logic  mon_en = 1'b0;
    time   t_rise;
    int    low_q[$];
    time   rise_q[$];
    always @(posedge dq_oe_o) if (mon_en) begin t_rise = $time; rise_q.push_back($time); end
    always @(negedge dq_oe_o) if (mon_en) low_q.push_back(int'(($time - t_rise) / 1000));

    // Behavioural slave: presence after reset, decodes the command, answers read slots
    int         cmd_cnt = 0;
    int         rd_cnt = 0;
    logic [7:0] cmd_rx = '0;
    always begin : slave_proc
        time t0;
        int  w;
        @(negedge bus);
        t0 = $time;
        if (slave_en && cmd_cnt == 8 && cmd_rx == 8'h33 && rd_cnt < 64 && !slave_rom[rd_cnt]) begin
            slave_pull = 1'b1;
            repeat (30 * US) @(posedge clk);
            slave_pull = 1'b0;
        end
        wait (bus === 1'b1);
        w = int'(($time - t0) / 1000);
        if (slave_en && w >= 400) begin
            cmd_cnt = 0;
            rd_cnt  = 0;
            cmd_rx  = '0;
            repeat (15 * US) @(posedge clk);
            slave_pull = 1'b1;
            repeat (100 * US) @(posedge clk);
            slave_pull = 1'b0;
        end else if (cmd_cnt < 8) begin
            cmd_rx[cmd_cnt] = (w < 15);
            cmd_cnt++;
        end else if (rd_cnt < 64) begin
            rd_cnt++;
        end
    end

    // Dallas CRC-8 of the first seven ROM bytes, byte by byte, LSB first
    function automatic logic [7:0] dallas_crc(input logic [55:0] data);
        logic [7:0] c;
        logic [7:0] b;
        c = 8'h00;
        for (int i = 0; i < 7; i++) begin
            b = data[8*i +: 8];
            for (int k = 0; k < 8; k++) begin
                if (c[0] ^ b[0]) c = (c >> 1) ^ 8'h8C;
                else             c = c >> 1;
                b = b >> 1;
            end
        end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        n_total++;
        assert (obs >= lo && obs <= hi) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Count cycles until done_o (bounded); optionally pulse start_i at cycle 'poke'
    task automatic wait_done(input int limit, input int poke, output int n);
        n = 0;
        while (n < limit) begin
            @(posedge clk); #1;
            n++;
            start_i = (n == poke);
            if (done_o) break;
        end
        start_i = 1'b0;
    endtask

    task automatic model_txn(input bit en, input logic [63:0] rom);
        e_crcerr = 1'b0;
        e_nopres = !en;
        if (en) begin
            if (dallas_crc(rom[55:0]) == rom[63:56]) begin
                e_id    = rom;
                e_valid = 1'b1;
            end else begin
                e_crcerr = 1'b1;
            end
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_id"},     id_o,          e_id);
        chk({tag, "_valid"},  valid_o,       e_valid);
        chk({tag, "_nopres"}, no_presence_o, e_nopres);
        chk({tag, "_crcerr"}, crc_err_o,     e_crcerr);
    endtask

    task automatic run_txn(input string tag, input bit en, input logic [63:0] rom);
        int n;
        int d0;
        int lo;
        slave_en  = en;
        slave_rom = rom;
        repeat (5) @(posedge clk);
        d0 = n_done;
        @(negedge clk); start_i = 1'b1;
        @(posedge clk); #1; start_i = 1'b0;
        chk({tag, "_busy"}, busy_o, 1'b1);
        wait_done(7000 * US, -1, n);
        model_txn(en, rom);
        lo = en ? 6000 * US : 960 * US;
        chk_rng({tag, "_latency"}, n, lo, lo + 4);
        chk_status(tag);
        repeat (3) @(posedge clk); #1;
        chk({tag, "_done_pulses"}, 64'(n_done - d0), 64'd1);
    endtask

    logic [63:0] rom;
    logic [7:0]  cmd_ref;
    int          n;
    int          bad;

    initial begin
        // Reset state
        repeat (5) @(posedge clk); #1;
        chk("rst_oe",     dq_oe_o,       1'b0);
        chk("rst_busy",   busy_o,        1'b0);
        chk("rst_done",   done_o,        1'b0);
        chk("rst_id",     id_o,          64'h0);
        chk("rst_valid",  valid_o,       1'b0);
        chk("rst_nopres", no_presence_o, 1'b0);
        chk("rst_crcerr", crc_err_o,     1'b0);

        // Auto-start with no slave; a start_i at 100 us must be dropped
        @(negedge clk); rstn = 1'b1;
        wait_done(2000 * US, 100 * US, n);
        model_txn(1'b0, '0);
        chk_rng("auto_latency", n, 960 * US, 960 * US + 4);
        chk_status("auto");
        repeat (2000 * US) @(posedge clk); #1;
        chk("auto_single_done", 64'(n_done), 64'd1);

        // Known-good ROM with bus monitor on the transmit phase
        low_q.delete();
        rise_q.delete();
        mon_en = 1'b1;
        run_txn("good", 1'b1, 64'hA200_0000_01B8_1C02);
        mon_en = 1'b0;
        chk("mon_pulse_count", 64'(low_q.size()), 64'd73);
        chk("mon_rst_low", 64'(low_q[0]), 64'd480);
        cmd_ref = 8'h33;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("tx_low%0d", i), 64'(low_q[1+i]), cmd_ref[i] ? 64'd6 : 64'd60);
            chk($sformatf("tx_slot%0d", i), 64'((rise_q[2+i] - rise_q[1+i]) / 1000), 64'd70);
        end
        bad = 0;
        for (int i = 9; i < 73; i++) if (low_q[i] != 6) bad++;
        chk("rx_low_widths", 64'(bad), 64'd0);

        // Same ROM, corrupted CRC: error flagged, previous ID retained
        run_txn("badcrc", 1'b1, 64'hA300_0000_01B8_1C02);

        // No slave after an error: error cleared, ID retained
        run_txn("nopres", 1'b0, '0);

        // Randomized ROMs, some with a corrupted CRC byte
        for (int t = 0; t < 3; t++) begin
            rom = {$urandom(), $urandom()};
            rom[63:56] = dallas_crc(rom[55:0]);
            if ($urandom_range(0, 1) == 1) rom[63:56] = rom[63:56] ^ (8'h01 << $urandom_range(0, 7));
            run_txn($sformatf("rand%0d", t), 1'b1, rom);
        end

        // Reset in the middle of the ROM read
        rom = {$urandom(), $urandom()};
        rom[63:56] = dallas_crc(rom[55:0]);
        slave_rom = rom;
        slave_en  = 1'b1;
        @(negedge clk); start_i = 1'b1;
        @(posedge clk); #1; start_i = 1'b0;
        repeat (3000 * US) @(posedge clk);
        @(negedge clk); rstn = 1'b0;
        @(posedge clk); #1;
        chk("midrst_oe",     dq_oe_o,       1'b0);
        chk("midrst_busy",   busy_o,        1'b0);
        chk("midrst_done",   done_o,        1'b0);
        e_id     = '0;
        e_valid  = 1'b0;
        e_nopres = 1'b0;
        e_crcerr = 1'b0;
        chk_status("midrst");
        repeat (50 * US) @(posedge clk);
        @(negedge clk); rstn = 1'b1;
        wait_done(7000 * US, 50 * US, n);
        model_txn(1'b1, rom);
        chk_rng("after_rst_latency", n, 6000 * US, 6000 * US + 5);
        chk_status("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
